color_frame_scheduler: RTL and testbench
========================================

COLOR_FRAME_SCHEDULER -- requirements
Module: color_frame_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200000: cycles allowed in WAIT_DONE before the pass is aborted.
REQ-002 Parameter RESET_COLOR, default 84'h0: display_color value after reset.
REQ-003 clock  input  1  system clock (100 MHz); all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; a clock edge with reset=0 SHALL reset the block.
REQ-005 fft_ready  input  1  one-cycle pulse; a new spectrum is available in FFT BRAM.
REQ-006 adjusting  input  1  level; color-offset adjust mode is active.
REQ-007 energy_start  output  1  one-cycle pulse; starts one energy/color pass.
REQ-008 energy_done  input  1  one-cycle pulse; the pass is complete and energy_color is valid.
REQ-009 energy_color  input  84  seven packed 12-bit colors; sampled only when energy_done=1.
REQ-010 vsync_n  input  1  VGA vertical sync from the 25 MHz domain, active-low and asynchronous to clock.
REQ-011 display_color  output  84  registered color set; the video path reads this value.
REQ-012 frame_swap  output  1  one-cycle pulse on the cycle display_color takes a new value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  sticky flag; a pass was aborted.
REQ-015 drop_count  output  8  count of fft_ready pulses not serviced; saturates at 255.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT_DONE and PENDING, with one-hot or binary encoding.
REQ-017 IDLE: fft_ready=1 and adjusting=0 SHALL go to START; fft_ready=1 with adjusting=1 SHALL be ignored and SHALL NOT be counted.
REQ-018 START: energy_start SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT_DONE.
REQ-019 Latency: fft_ready sampled at edge N SHALL give energy_start=1 in the cycle after edge N+1, then 0.
REQ-020 WAIT_DONE: energy_done=1 SHALL latch energy_color into an internal back buffer and go to PENDING.
REQ-021 WAIT_DONE: a 32-bit timeout counter SHALL clear on entry and increment each cycle.
REQ-022 WAIT_DONE timeout: when the counter reaches TIMEOUT_CYCLES-1 with energy_done=0, timeout_err SHALL set and the FSM SHALL go to IDLE; the back buffer and display_color SHALL be unchanged.
REQ-023 If energy_done and timeout occur in the same cycle, energy_done SHALL win and timeout_err SHALL NOT set.
REQ-024 Once a pass has started, it SHALL complete even if adjusting rises in START, WAIT_DONE or PENDING.
REQ-025 energy_done outside WAIT_DONE SHALL be ignored.
REQ-026 vsync_n SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; all three SHALL reset to 1.
REQ-027 vfall = s3 & ~s2 SHALL be the only vsync event.
REQ-028 PENDING: on vfall=1, display_color SHALL load the back buffer at that edge, frame_swap SHALL pulse for one cycle, and the FSM SHALL go to IDLE.
REQ-029 display_color SHALL change only per REQ-028, so it never changes mid-frame.
REQ-030 If vsync_n is sampled low by s1 at edge k, display_color SHALL update at edge k+2.
REQ-031 fft_ready=1 in any state other than IDLE SHALL increment drop_count, saturating at 255, with no wrap.
REQ-032 fft_ready in the same cycle as a PENDING-to-IDLE swap SHALL be counted as a drop and SHALL NOT start a pass.
REQ-033 vfall outside PENDING SHALL have no effect.

Reset
REQ-034 Reset SHALL set: state IDLE, energy_start 0, frame_swap 0, busy 0, timeout_err 0, drop_count 0, display_color RESET_COLOR, back buffer RESET_COLOR, timeout counter 0, s1/s2/s3 = 1.
REQ-035 Reset asserted in any state, mid-pass included, SHALL take effect at that edge; a later energy_done SHALL be ignored.
REQ-036 timeout_err SHALL clear only by reset.

Verification (TIMEOUT_CYCLES=16)
REQ-037 fft_ready pulse, adjusting=0 -> energy_start 2 edges later; energy_done with color 84'h00F_00C_00A_008_006_004_003 -> display_color unchanged until vsync_n falls; 2 edges later display_color=that value, frame_swap one pulse.
REQ-038 fft_ready with adjusting=1 in IDLE -> no energy_start, drop_count=0, busy=0.
REQ-039 start a pass, withhold energy_done -> after 16 cycles in WAIT_DONE: timeout_err=1, state IDLE, display_color unchanged; next fft_ready starts a new pass normally.
REQ-040 300 fft_ready pulses while in PENDING -> drop_count=255, then a swap on vsync_n fall.
REQ-041 energy_done and timeout in the same cycle -> PENDING, timeout_err=0.
REQ-042 reset=0 during WAIT_DONE, energy_done after release -> remains IDLE, display_color=RESET_COLOR, no frame_swap.

Source files
------------

// File: rtl/color_frame_scheduler.sv
// Sequences one energy/color pass per FFT spectrum and double-buffers the resulting color set.
// Latency: energy_start follows fft_ready by two edges; display_color loads two edges after s1 samples vsync_n low.
// Backpressure: fft_ready outside IDLE is dropped and counted; a stalled pass aborts after TIMEOUT_CYCLES.
module color_frame_scheduler #(
    parameter int unsigned  TIMEOUT_CYCLES = 200000,
    parameter logic [83:0]  RESET_COLOR    = 84'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fft_ready,
    input  logic        adjusting,
    output logic        energy_start,
    input  logic        energy_done,
    input  logic [83:0] energy_color,
    input  logic        vsync_n,
    output logic [83:0] display_color,
    output logic        frame_swap,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        PENDING   = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [83:0] back_q, back_d;
    logic [83:0] disp_q, disp_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  drop_q, drop_d;
    logic        start_q, start_d;
    logic        swap_q, swap_d;
    logic        terr_q, terr_d;

    logic        s1_q, s2_q, s3_q;
    logic        vfall;

    // vsync_n crosses from the pixel clock domain: two sync flops plus a history flop for edge detect
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= vsync_n;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign vfall = s3_q & ~s2_q;

    // Next-state and datapath decisions; energy_start is registered so it lands one edge after START
    always_comb begin
        state_d = state_q;
        back_d  = back_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        start_d = 1'b0;
        swap_d  = 1'b0;
        drop_d  = drop_q;

        // Any spectrum arriving while a pass is in flight is lost; saturate rather than wrap
        if (fft_ready && (state_q != IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (fft_ready && !adjusting) begin
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = 32'd0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // energy_done takes priority over an expiring timeout in the same cycle
                if (energy_done) begin
                    back_d  = energy_color;
                    state_d = PENDING;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            PENDING: begin
                // Swap only at the start of vertical blanking so a frame never shows mixed colors
                if (vfall) begin
                    disp_d  = back_q;
                    swap_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            back_q  <= RESET_COLOR;
            disp_q  <= RESET_COLOR;
            cnt_q   <= 32'd0;
            terr_q  <= 1'b0;
            start_q <= 1'b0;
            swap_q  <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            back_q  <= back_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            start_q <= start_d;
            swap_q  <= swap_d;
            drop_q  <= drop_d;
        end
    end

    assign energy_start  = start_q;
    assign frame_swap    = swap_q;
    assign display_color = disp_q;
    assign timeout_err   = terr_q;
    assign drop_count    = drop_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_color_frame_scheduler.sv
// Randomized scoreboard bench for color_frame_scheduler with a short timeout.
// Expected events are queued by the stimulus and consumed by a negedge monitor.
// Drops, the sticky error and the displayed color are tracked by a high-level model.
module tb_color_frame_scheduler;

    localparam int          T  = 16;
    localparam logic [83:0] RC = 84'hABC_DEF_012_345_678_9AB_CDE;

    logic        clock;
    logic        reset;
    logic        fft_ready;
    logic        adjusting;
    logic        energy_start;
    logic        energy_done;
    logic [83:0] energy_color;
    logic        vsync_n;
    logic [83:0] display_color;
    logic        frame_swap;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  drop_count;

    color_frame_scheduler #(
        .TIMEOUT_CYCLES(T),
        .RESET_COLOR   (RC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fft_ready    (fft_ready),
        .adjusting    (adjusting),
        .energy_start (energy_start),
        .energy_done  (energy_done),
        .energy_color (energy_color),
        .vsync_n      (vsync_n),
        .display_color(display_color),
        .frame_swap   (frame_swap),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .drop_count   (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_swap;
        int          at;
        logic [83:0] col;
    } ev_t;

    ev_t         evq[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [83:0] exp_disp = RC;
    int          drop_exp = 0;
    bit          exp_terr = 1'b0;

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the next queued expectation, display must track the model
    always @(negedge clock) begin
        if (chk_en) begin
            if (energy_start || frame_swap) begin
                if (evq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got start=%0b swap=%0b expected none (cycle %0d)",
                             energy_start, frame_swap, cyc);
                end else begin
                    ev_t ev;
                    ev = evq.pop_front();
                    check("event_kind_swap", {83'd0, frame_swap}, {83'd0, ev.is_swap});
                    check("event_cycle", 84'(cyc), 84'(ev.at));
                    if (ev.is_swap) exp_disp = ev.col;
                end
            end
            check("display_color", display_color, exp_disp);
        end
    end

    function automatic bit rnd(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    function automatic logic [83:0] rnd_col();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[83:0];
    endfunction

    task automatic note_drop(input bit ff);
        if (ff && drop_exp < 255) drop_exp++;
    endtask

    task automatic tick(input bit ff, input bit adj, input bit dn, input logic [83:0] col, input bit vs);
        fft_ready    = ff;
        adjusting    = adj;
        energy_done  = dn;
        energy_color = col;
        vsync_n      = vs;
        @(posedge clock);
        #1;
        fft_ready   = 1'b0;
        energy_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(0, 0, 0, '0, 1);
        exp_disp = RC;
        tick(0, 0, 0, '0, 1);
        reset    = 1'b1;
        drop_exp = 0;
        exp_terr = 1'b0;
        evq.delete();
    endtask

    // One pass: j = cycle of energy_done inside WAIT_DONE (1..T), 0 = withhold it and let it time out
    task automatic run_pass(input logic [83:0] col, input int j, input int vdel,
                            input bit noisy, input bit early_vs, input bit flood);
        int N;
        int k;
        bit ff;
        tick(1, 0, 0, '0, 1);
        N = cyc;
        evq.push_back(ev_t'{1'b0, N + 1, '0});
        ff = noisy && rnd(30);
        tick(ff, noisy && rnd(50), noisy && rnd(30), rnd_col(), !early_vs);
        note_drop(ff);
        for (int i = 1; i <= T; i++) begin
            bit d;
            d  = (i == j);
            ff = noisy && rnd(20);
            if (j == 0 && i == T) begin
                check("busy_before_timeout", {83'd0, busy}, 84'd1);
                check("terr_before_timeout", {83'd0, timeout_err}, {83'd0, exp_terr});
            end
            tick(ff, noisy && rnd(50), d, d ? col : rnd_col(), !(early_vs && i == 1));
            note_drop(ff);
            if (d) break;
        end
        if (j == 0) begin
            exp_terr = 1'b1;
            check("timeout_err_set", {83'd0, timeout_err}, 84'd1);
            check("busy_after_timeout", {83'd0, busy}, 84'd0);
        end else begin
            check("busy_pending", {83'd0, busy}, 84'd1);
            check("terr_after_done", {83'd0, timeout_err}, {83'd0, exp_terr});
            for (int i = 0; i < vdel; i++) begin
                ff = flood || (noisy && rnd(20));
                tick(ff, noisy && rnd(50), noisy && rnd(20), rnd_col(), 1);
                note_drop(ff);
            end
            check("drop_before_swap", {76'd0, drop_count}, 84'(drop_exp));
            ff = noisy && rnd(30);
            tick(ff, noisy && rnd(50), 0, rnd_col(), 0);
            note_drop(ff);
            k = cyc;
            evq.push_back(ev_t'{1'b1, k + 2, col});
            for (int i = 0; i < 2; i++) begin
                ff = noisy && rnd(30);
                tick(ff, noisy && rnd(50), 0, rnd_col(), 0);
                note_drop(ff);
            end
            check("busy_after_swap", {83'd0, busy}, 84'd0);
        end
        repeat (3) tick(0, noisy && rnd(50), noisy && rnd(30), rnd_col(), 1);
        check("drop_count", {76'd0, drop_count}, 84'(drop_exp));
        check("timeout_err", {83'd0, timeout_err}, {83'd0, exp_terr});
    endtask

    initial begin
        reset        = 1'b0;
        fft_ready    = 1'b0;
        adjusting    = 1'b0;
        energy_done  = 1'b0;
        energy_color = '0;
        vsync_n      = 1'b1;
        do_reset();
        chk_en = 1'b1;

        check("rst_busy", {83'd0, busy}, 84'd0);
        check("rst_start", {83'd0, energy_start}, 84'd0);
        check("rst_swap", {83'd0, frame_swap}, 84'd0);
        check("rst_terr", {83'd0, timeout_err}, 84'd0);
        check("rst_drop", {76'd0, drop_count}, 84'd0);
        check("rst_display", display_color, RC);

        // Basic pass, with a vsync fall during WAIT_DONE that must be ignored
        run_pass(84'h00F_00C_00A_008_006_004_003, 5, 4, 0, 1, 0);

        // Spectrum during adjust mode in IDLE: no pass, not counted
        tick(1, 1, 0, '0, 1);
        repeat (4) tick(0, 1, 0, '0, 1);
        check("adj_busy", {83'd0, busy}, 84'd0);
        check("adj_drop", {76'd0, drop_count}, 84'd0);
        adjusting = 1'b0;

        // energy_done on the final timeout cycle wins
        run_pass(rnd_col(), T, 2, 0, 0, 0);
        check("sametime_terr", {83'd0, timeout_err}, 84'd0);

        // Timeout, then a normal pass recovers
        run_pass(rnd_col(), 0, 0, 0, 0, 0);
        run_pass(rnd_col(), 2, 1, 0, 0, 0);

        // Randomized passes with drops, adjust toggling and spurious energy_done
        for (int p = 0; p < 25; p++) begin
            int jj;
            bit ev;
            jj = rnd(15) ? 0 : int'($urandom_range(T, 1));
            ev = (jj >= 3) && rnd(30);
            run_pass(rnd_col(), jj, int'($urandom_range(6, 0)), 1, ev, 0);
        end

        // Flood of spectra while pending saturates the drop counter
        run_pass(rnd_col(), 3, 300, 0, 0, 1);
        check("drop_saturated", {76'd0, drop_count}, 84'd255);

        // Reset mid-pass: a later energy_done is ignored
        tick(1, 0, 0, '0, 1);
        evq.push_back(ev_t'{1'b0, cyc + 1, '0});
        repeat (4) tick(0, 0, 0, '0, 1);
        do_reset();
        tick(0, 0, 1, rnd_col(), 1);
        repeat (3) tick(0, 0, 0, '0, 1);
        check("post_rst_busy", {83'd0, busy}, 84'd0);
        check("post_rst_terr", {83'd0, timeout_err}, 84'd0);
        check("post_rst_drop", {76'd0, drop_count}, 84'd0);
        repeat (4) tick(0, 0, 0, '0, 0);
        repeat (4) tick(0, 0, 0, '0, 1);
        check("post_rst_display", display_color, RC);
        run_pass(rnd_col(), 4, 2, 0, 0, 0);

        repeat (3) tick(0, 0, 0, '0, 1);
        n_chk++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d outstanding expected 0", evq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
